sd_sector_buffer: RTL
=====================

# sd_sector_buffer

Downstream consumer of the SPI SD session engine's data-readout port (`rvalid`/`rindex`/`rdata`). Captures each 512-byte data block plus its 2-byte CRC16 into one of two RAM banks (ping-pong) and checks the CRC. It then streams completed sectors to the user over a valid/ready byte stream, with a per-sector CRC verdict. Capture of the next sector overlaps with streaming of the previous one.

## Interface
- No parameters; sector size fixed at 512 data bytes + 2 CRC bytes.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rvalid` in 1: readout byte strobe from session engine.
- `rindex` in 16: readout index; counts down 513..0 within a block.
- `rdata` in 8: readout byte.
- `cap_clear` in 1: abandon any partial capture; driven when a session ends or aborts.
- `m_valid` out 1: output byte valid.
- `m_ready` in 1: output byte accepted.
- `m_data` out 8: sector byte.
- `m_offset` out 9: byte offset within sector, 0..511.
- `m_last` out 1: high with offset 511.
- `m_crc_ok` out 1: CRC verdict of the sector being streamed; constant for the whole sector.
- `full` out 1: both banks hold completed, unstreamed sectors.
- `capturing` out 1: a capture is in progress.
- `overflow` out 1: sticky; a sector was dropped for lack of a free bank.
- `seq_err` out 1: sticky; an out-of-order `rindex` was detected.

## Operation
- Index map: `rindex` 513..2 are data bytes at address 513−rindex (0..511). `rindex` 1 is CRC high byte; `rindex` 0 is CRC low byte.
- Capture FSM states: IDLE, CAP, DROP.
  - IDLE + `rvalid` with `rindex`=513 and a free bank → CAP, write byte 0.
  - IDLE + `rvalid` with `rindex`=513 and no free bank → DROP, set `overflow`.
  - IDLE + `rvalid` with any other `rindex` → ignored, set `seq_err`.
- CAP: expected index decrements on each accepted byte. Each `rvalid` must carry the expected index.
  - On mismatch: discard the partial sector and set `seq_err`. If the offending index is 513, begin a fresh capture (same bank); otherwise go to IDLE.
- After the `rindex`=0 byte: the bank is marked complete with `crc_ok` = (received CRC == computed CRC). FSM returns to IDLE.
- DROP: ignore bytes until the `rindex`=0 byte, then go to IDLE. An `rindex`=513 byte seen in DROP is treated as in IDLE.
- CRC: CRC16-CCITT, poly 0x1021, init 0x0000, MSB-first, no final XOR, computed over the 512 data bytes only. Byte-wise update, one byte per cycle.
- Banks fill and stream strictly in alternation 0,1,0,… A bank is free only after its `m_last` handshake.
- `cap_clear` returns the FSM to IDLE and frees the bank being filled. Completed banks and the stream in progress are unaffected. `cap_clear` and `rvalid` in the same cycle: `cap_clear` wins and the byte is dropped.
- `overflow` and `seq_err` are cleared only by `rst`.

## Timing
- All outputs are registered. Reset values: `m_valid`=0, `m_data`=0, `m_offset`=0, `m_last`=0, `m_crc_ok`=0, `full`=0, `capturing`=0, `overflow`=0, `seq_err`=0. Both banks free, FSM in IDLE.
- `rst` mid-capture or mid-stream discards everything on the next edge.
- Capture accepts `rvalid` on every cycle, including back-to-back.
- `capturing` rises the cycle after the 513 byte and falls the cycle after the 0 byte.
- The bank becomes complete on the edge after the `rindex`=0 byte. `m_valid` for byte 0 of that sector must assert no more than 2 cycles later, if the stream is idle.
- RAM read latency is 1 cycle, hidden by a prefetch/skid register. With `m_ready` held high, the stream runs one byte per cycle with no bubbles inside a sector.
- At most 2 idle cycles between `m_last` of one bank and byte 0 of the next ready bank.
- While `m_valid`=1 and `m_ready`=0, `m_data`, `m_offset`, `m_last` and `m_crc_ok` hold stable.
- `full` updates on the same edge as the completion or release that causes it. The same edge may both complete one bank and release the other; `full` then stays 0.

## Test plan
- **All-0xFF sector:** 514 `rvalid` bytes (`rindex` 513..0), data 0xFF, CRC 0x7F,0xA1, `m_ready`=1 → 512 bytes of 0xFF at offsets 0..511, `m_last` at 511, `m_crc_ok`=1.
- **Bad CRC:** same sector with CRC 0x00,0x00 → sector still streamed, `m_crc_ok`=0. Incrementing data 0x00..0xFF twice with correct CRC → `m_crc_ok`=1.
- **Backpressure and overflow:** `m_ready`=0 while three sectors arrive → `full`=1 after the second, third dropped, `overflow`=1. Raise `m_ready` → first two sectors stream in order, intact.
- **Sequence error:** skip `rindex` 300 mid-sector → `seq_err`=1, no output from that sector. Next well-formed sector streams normally.
- **Abort:** `cap_clear` at `rindex` 100 while bank 0 streams → bank 0 completes its stream unchanged, no partial output. A fresh sector is then captured correctly.
- **Reset mid-stream:** `rst` at offset 200 → next cycle all outputs at reset values and no further bytes emitted.

Source files
------------

// File: rtl/sd_sector_buffer.sv
// Ping-pong capture of SD data blocks with CRC16 check,
// streamed out as a valid/ready byte stream with per-sector verdict.
module sd_sector_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        rvalid,
  input  logic [15:0] rindex,
  input  logic [7:0]  rdata,
  input  logic        cap_clear,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic [8:0]  m_offset,
  output logic        m_last,
  output logic        m_crc_ok,
  output logic        full,
  output logic        capturing,
  output logic        overflow,
  output logic        seq_err
);

  typedef enum logic [1:0] {IDLE, CAP, DROP} st_t;

  typedef struct packed {
    logic [7:0] d;
    logic [8:0] off;
    logic       bank;
    logic       ok;
  } item_t;

  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021)
                : {r[14:0], 1'b0};
    return r;
  endfunction

  logic [7:0]  mem [0:1023];
  st_t         st;
  logic        wr_bank;
  logic [9:0]  nxt_idx;
  logic [15:0] crc;
  logic [7:0]  crc_hi;
  logic [1:0]  done, done_n, ok;

  logic       first, match, free, we;
  logic       complete, crc_good;
  logic [8:0] wa;

  assign first    = rindex == 16'd513;
  assign match    = rindex == {6'd0, nxt_idx};
  assign free     = !done[wr_bank];
  assign wa       = 9'd1 - rindex[8:0];
  assign complete = rvalid && !cap_clear && st == CAP &&
                    match && nxt_idx == 10'd0;
  assign crc_good = {crc_hi, rdata} == crc;

  always_comb begin
    we = 1'b0;
    if (rvalid && !cap_clear) begin
      if (st == CAP) we = match ? (nxt_idx >= 10'd2) : first;
      else           we = first && free;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      wr_bank   <= 1'b0;
      nxt_idx   <= '0;
      crc       <= '0;
      crc_hi    <= '0;
      capturing <= 1'b0;
      overflow  <= 1'b0;
      seq_err   <= 1'b0;
    end else if (cap_clear) begin
      st        <= IDLE;
      capturing <= 1'b0;
    end else if (rvalid) begin
      case (st)
        CAP: begin
          if (!match) begin
            seq_err <= 1'b1;
            if (first) begin
              nxt_idx <= 10'd512;
              crc     <= crc_upd(16'h0000, rdata);
            end else begin
              st        <= IDLE;
              capturing <= 1'b0;
            end
          end else begin
            nxt_idx <= nxt_idx - 10'd1;
            if (nxt_idx >= 10'd2) crc <= crc_upd(crc, rdata);
            if (nxt_idx == 10'd1) crc_hi <= rdata;
            if (nxt_idx == 10'd0) begin
              st        <= IDLE;
              capturing <= 1'b0;
              wr_bank   <= ~wr_bank;
            end
          end
        end
        default: begin
          if (first) begin
            if (free) begin
              st        <= CAP;
              capturing <= 1'b1;
              nxt_idx   <= 10'd512;
              crc       <= crc_upd(16'h0000, rdata);
            end else begin
              st       <= DROP;
              overflow <= 1'b1;
            end
          end else if (st == IDLE) begin
            seq_err <= 1'b1;
          end else if (rindex == 16'd0) begin
            st <= IDLE;
          end
        end
      endcase
    end
  end

  // stream side: read issue -> RAM register -> skid -> output
  logic       iss_bank, rd_req, sk_v, pop, load, issue;
  logic [8:0] iss_off, rq_off;
  logic       rq_bank, rq_ok;
  logic [7:0] ram_q;
  logic [1:0] occ;
  item_t      sk, o, ram_i;

  assign pop   = m_valid && m_ready;
  assign load  = !m_valid || m_ready;
  assign occ   = {1'b0, m_valid} + {1'b0, sk_v} + {1'b0, rd_req};
  assign issue = done[iss_bank] && (occ - {1'b0, pop}) <= 2'd1;
  assign ram_i = '{d: ram_q, off: rq_off, bank: rq_bank, ok: rq_ok};

  assign m_data   = o.d;
  assign m_offset = o.off;
  assign m_crc_ok = o.ok;

  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wa}] <= rdata;
    if (issue) ram_q <= mem[{iss_bank, iss_off}];
  end

  always_comb begin
    done_n = done;
    if (pop && m_last) done_n[o.bank] = 1'b0;
    if (complete) done_n[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= '0;
      ok   <= '0;
      full <= 1'b0;
    end else begin
      done <= done_n;
      full <= &done_n;
      if (complete) ok[wr_bank] <= crc_good;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_bank <= 1'b0;
      iss_off  <= '0;
      rd_req   <= 1'b0;
      rq_off   <= '0;
      rq_bank  <= 1'b0;
      rq_ok    <= 1'b0;
      sk_v     <= 1'b0;
      sk       <= '0;
      o        <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
    end else begin
      rd_req <= issue;
      if (issue) begin
        iss_off <= iss_off + 9'd1;
        if (iss_off == 9'd511) iss_bank <= ~iss_bank;
        rq_off  <= iss_off;
        rq_bank <= iss_bank;
        rq_ok   <= ok[iss_bank];
      end
      if (load) begin
        if (sk_v) begin
          o       <= sk;
          m_last  <= sk.off == 9'd511;
          m_valid <= 1'b1;
          sk_v    <= rd_req;
          if (rd_req) sk <= ram_i;
        end else if (rd_req) begin
          o       <= ram_i;
          m_last  <= ram_i.off == 9'd511;
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (rd_req) begin
        sk   <= ram_i;
        sk_v <= 1'b1;
      end
    end
  end

endmodule
